// File: rtl/edsac_acc_pkg.sv
// ----------------------------------------------------------------------------
// edsac_acc_pkg
// Shared definitions for the serial accumulator shift executor:
//   - default accumulator width (digits per minor cycle) and shift-count width
//   - phase counter width helper and its default value
//   - controller state encoding and the decoded word-boundary command
// ----------------------------------------------------------------------------
package edsac_acc_pkg;

    localparam int ACC_W_DEF = 71;
    localparam int CNT_W_DEF = 7;

    // A phase counter needs at least one bit, even for a degenerate 1-digit word.
    function automatic int phase_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PHASE_W_DEF = phase_w(ACC_W_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } acc_state_e;

    // Command decoded at the word boundary after priority resolution.
    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_CLEAR  = 3'd1,
        CMD_LOAD   = 3'd2,
        CMD_LSHIFT = 3'd3,
        CMD_RSHIFT = 3'd4,
        CMD_HOLD   = 3'd5   // x1 and x2 together: no shift, no count
    } acc_cmd_e;

endpackage

// File: rtl/acc_phase_ctr.sv
// ----------------------------------------------------------------------------
// acc_phase_ctr
// Digit-phase counter for the serial accumulator. Counts 0..ACC_W-1 and wraps,
// so one full count is one minor cycle.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   phase       : current digit position (0 = LSB)
//   d0          : high while phase == 0
//   last        : high while phase == ACC_W-1 (word boundary on the next edge)
// ----------------------------------------------------------------------------
module acc_phase_ctr
    import edsac_acc_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int PHASE_W = phase_w(ACC_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PHASE_W-1:0] phase,
    output logic               d0,
    output logic               last
);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(ACC_W - 1);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;

    always_comb begin
        phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + PHASE_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;
    assign d0    = (phase_q == '0);
    assign last  = (phase_q == LAST_PHASE);

endmodule

// File: rtl/acc_shift_exec.sv
// ----------------------------------------------------------------------------
// acc_shift_exec
// Serial accumulator with word-boundary shift/clear/load orders. The tank is
// held in parallel and presented one digit per clock, LSB first, on acc.
// Commands are sampled only on the last digit of a word and take effect at
// that edge; mob8 aborts an active order at any clock and produces done.
//
// Optional feature: define ACC_SHIFT_OVF_DETECT_EN to enable the sticky
// left-shift overflow flag; otherwise ovf is tied low.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   x1 / x2         : left / right shift enable
//   x3              : clear accumulator and shift count
//   x4              : serial load of the next word from sin
//   mob8            : end-of-order strobe
//   sin             : serial load data, LSB first, aligned to d0
//   acc             : serial accumulator stream, LSB first
//   sign            : accumulator MSB
//   d0              : high on the clock carrying digit 0
//   busy            : order in progress (SHIFT or LOAD)
//   done            : one-clock completion pulse
//   shift_cnt       : shifts applied in the current/last order (saturating)
//   ovf             : sticky left-shift overflow
// ----------------------------------------------------------------------------
module acc_shift_exec
    import edsac_acc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x1,
    input  logic             x2,
    input  logic             x3,
    input  logic             x4,
    input  logic             mob8,
    input  logic             sin,
    output logic             acc,
    output logic             sign,
    output logic             d0,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             ovf
);

    localparam int PHASE_W = phase_w(ACC_W);

    logic [PHASE_W-1:0] phase;
    logic               last;

    acc_phase_ctr #(
        .ACC_W   (ACC_W),
        .PHASE_W (PHASE_W)
    ) u_phase_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .phase (phase),
        .d0    (d0),
        .last  (last)
    );

    logic [ACC_W-1:0] tank_q, tank_d;
    acc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    acc_cmd_e         cmd;

    // Boundary command decode: only IDLE and SHIFT accept new commands.
    always_comb begin
        cmd = CMD_NONE;
        if (last && (state_q == IDLE || state_q == SHIFT)) begin
            if (x3)           cmd = CMD_CLEAR;
            else if (x4)      cmd = CMD_LOAD;
            else if (x1 & x2) cmd = CMD_HOLD;
            else if (x1)      cmd = CMD_LSHIFT;
            else if (x2)      cmd = CMD_RSHIFT;
        end
    end

    // NOTE: every variable gets its default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        tank_d  = tank_q;
        state_d = state_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE, SHIFT: begin
                unique case (cmd)
                    CMD_CLEAR: begin
                        tank_d  = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                    CMD_LOAD: begin
                        state_d = LOAD;
                    end
                    CMD_LSHIFT, CMD_RSHIFT: begin
                        tank_d = (cmd == CMD_LSHIFT)
                               ? {tank_q[ACC_W-2:0], 1'b0}
                               : {tank_q[ACC_W-1], tank_q[ACC_W-1:1]};
                        // A new order restarts the count at its first shift.
                        if (state_q == IDLE)
                            cnt_d = CNT_W'(1);
                        else if (!(&cnt_q))
                            cnt_d = cnt_q + CNT_W'(1);
                        state_d = SHIFT;
                    end
                    CMD_HOLD: begin
                        state_d = state_q;
                    end
                    default: begin
                        // Boundary with no shift request ends a shift order.
                        if (last) state_d = IDLE;
                    end
                endcase
            end
            LOAD: begin
                // Serial input replaces the recirculated digit.
                tank_d[phase] = sin;
                if (last) state_d = IDLE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // mob8 terminates an active order after this edge's action completes.
        if (mob8 && (state_q == SHIFT || state_q == LOAD))
            state_d = DONE;
    end

    // NOTE: the tank is a flop array with a true asynchronous reset (not a
    // RAM), so acc and sign read zero as soon as rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tank_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            tank_q  <= tank_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ACC_SHIFT_OVF_DETECT_EN
    logic ovf_q, ovf_d;

    // Left shift overflows when the two top digits differ before the shift.
    always_comb begin
        ovf_d = ovf_q;
        if (cmd == CMD_LSHIFT && (tank_q[ACC_W-1] != tank_q[ACC_W-2]))
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign acc       = tank_q[phase];
    assign sign      = tank_q[ACC_W-1];
    assign busy      = (state_q == SHIFT) || (state_q == LOAD);
    assign done      = (state_q == DONE);
    assign shift_cnt = cnt_q;

endmodule
